// File: rtl/cnt_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package cnt_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 3;
  // Requester index width; NREQ is at most 8.
  localparam int IDXW     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [IDXW-1:0] oh2idx(input logic [7:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = idx | IDXW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cnt_sched_if.sv
// Requester-side bus of the counter scheduler.
interface cnt_sched_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] limit;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      cnt;
  logic               tc;
  logic [NREQ-1:0]    done;
  logic               abort;
  logic               busy;

  modport master (
    output req, limit,
    input  gnt, cnt, tc, done, abort, busy
  );

  modport slave (
    input  req, limit,
    output gnt, cnt, tc, done, abort, busy
  );
endinterface

// File: rtl/cnt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDXW-1:0] win_idx
);

  logic found_s;

  // Scan offsets 0..NREQ-1 from the pointer, wrapping, and keep the first hit.
  always_comb begin
    win_oh  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found_s && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          win_oh[i] = 1'b1;
          found_s   = 1'b1;
        end else begin
          found_s   = found_s;
        end
      end
    end
  end

  assign win_idx = oh2idx(8'(win_oh));

endmodule

// File: rtl/cnt_sched.sv
// Shares one modulo-(limit+1) up-counter among NREQ requesters, round-robin.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  cnt_sched_if.slave  bus
);

  state_t          state_r, state_n_s;
  logic [NREQ-1:0] gnt_r, gnt_n_s, done_r, done_n_s, win_oh_s;
  logic [CW-1:0]   cnt_r, cnt_n_s, lim_r, lim_n_s, win_lim_s;
  logic [IDXW-1:0] ptr_r, ptr_n_s, win_idx_s;
  logic            abort_r, abort_n_s, busy_r;
  logic            any_req_s, owner_req_s, at_lim_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_r),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s)
  );

  assign any_req_s   = |bus.req;
  assign owner_req_s = |(bus.req & gnt_r);
  assign at_lim_s    = (cnt_r == lim_r);
  assign win_lim_s   = bus.limit[win_idx_s*CW +: CW];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state decode; a dropped owner request takes priority over terminal count.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_n_s = RUN;
        else           state_n_s = IDLE;
      end
      RUN: begin
        if (!owner_req_s)  state_n_s = IDLE;
        else if (at_lim_s) state_n_s = DONE;
        else               state_n_s = RUN;
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, limit latch and rr pointer.
  always_comb begin
    gnt_n_s   = gnt_r;
    cnt_n_s   = cnt_r;
    done_n_s  = '0;
    abort_n_s = 1'b0;
    lim_n_s   = lim_r;
    ptr_n_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          gnt_n_s = win_oh_s;
          cnt_n_s = '0;
          lim_n_s = win_lim_s;
          ptr_n_s = (win_idx_s == IDXW'(NREQ - 1)) ? '0 : win_idx_s + IDXW'(1'b1);
        end else begin
          gnt_n_s = '0;
          cnt_n_s = '0;
        end
      end
      RUN: begin
        if (!owner_req_s) begin
          gnt_n_s   = '0;
          cnt_n_s   = '0;
          abort_n_s = 1'b1;
        end else if (at_lim_s) begin
          done_n_s  = gnt_r;
          gnt_n_s   = '0;
          cnt_n_s   = '0;
        end else begin
          cnt_n_s   = cnt_r + CW'(1'b1);
        end
      end
      DONE: begin
        gnt_n_s = '0;
        cnt_n_s = '0;
      end
      default: begin
        gnt_n_s = '0;
        cnt_n_s = '0;
      end
    endcase
  end

  // Output, limit-latch and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_r   <= '0;
      cnt_r   <= '0;
      done_r  <= '0;
      abort_r <= 1'b0;
      busy_r  <= 1'b0;
      lim_r   <= '0;
      ptr_r   <= '0;
    end else begin
      gnt_r   <= gnt_n_s;
      cnt_r   <= cnt_n_s;
      done_r  <= done_n_s;
      abort_r <= abort_n_s;
      busy_r  <= (state_n_s != IDLE);
      lim_r   <= lim_n_s;
      ptr_r   <= ptr_n_s;
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.cnt   = cnt_r;
  assign bus.tc    = (state_r == RUN) && at_lim_s;
  assign bus.done  = done_r;
  assign bus.abort = abort_r;
  assign bus.busy  = busy_r;

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Round-robin scheduler that shares one modulo-(limit+1) up-counter between NREQ requesters.
- Each requester asks for one counting pass of its own length. The scheduler grants the counter, runs it 0..limit and signals terminal count and completion back to the owner.
- Sits beside the fixed-modulus counters as the common sequencing and timing resource for several client blocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 3, counter width; per-requester limit is CW bits (default covers mod-5 with limit=4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  NREQ  level request per requester; held high for the whole pass.
- limit  in  NREQ*CW  packed terminal values, requester i at bits [i*CW +: CW].
- gnt  out  NREQ  one-hot owner of the counter; all-zero when free.
- cnt  out  CW  shared counter value.
- tc  out  1  high in the cycle cnt equals the latched limit while running.
- done  out  NREQ  one-cycle one-hot pulse to the owner on normal completion.
- abort  out  1  one-cycle pulse when a pass is cancelled by the owner dropping req.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst=0: state=IDLE, gnt=0, cnt=0, tc=0, done=0, abort=0, busy=0, round-robin pointer=0, latched limit=0.
- Registered outputs: all outputs are registered except tc, which is decoded from cnt and the latched limit in state RUN.
- States: IDLE, RUN, DONE.
- IDLE: if any req bit is high, the rr arbiter picks the winner (first requester at or after the pointer, ascending, wrapping).
  - Next cycle: gnt=onehot(winner), cnt=0, limit latched from the winner's field, pointer=winner+1 mod NREQ, state=RUN.
  - If no req bit is high: stay in IDLE.
- RUN, owner req high, cnt<limit: cnt increments by 1.
- RUN, owner req high, cnt==limit: tc=1 this cycle. Next cycle: state=DONE, done=gnt, gnt=0, cnt=0.
- RUN, owner req low (checked before the compare): next cycle state=IDLE, gnt=0, cnt=0, abort=1 for one cycle, no done pulse.
- DONE: lasts one cycle; state=IDLE next cycle. done is cleared when leaving DONE.
- Grant latency: req rising in IDLE gives gnt the next cycle.
- Pass length: limit+1 cycles in RUN.
- Gap between passes: 2 cycles of gnt=0 between back-to-back grants (DONE, then IDLE).
- limit=0: a single RUN cycle with cnt=0 and tc=1, then DONE.
- limit = 2^CW-1: cnt reaches all-ones and never overflows, because completion precedes wrap.
- Limit stability: the latched limit is stable for the whole pass; changes on the limit input during RUN are ignored.
- Non-owner req changes during RUN are ignored until IDLE.
- A requester holding req through done is treated as a new request. Round-robin ensures every other pending requester is served first.
- Reset mid-RUN: immediate return to reset values, no done or abort pulse.
- Fairness: with all req bits high, the grant order is 0,1,...,NREQ-1,0,...

Decomposition:
- Package cnt_sched_pkg holds:
  - state enum {IDLE, RUN, DONE} (2 bits);
  - localparam defaults for NREQ and CW;
  - onehot-to-index helper function.
- Sub-module rr_arbiter (NREQ): inputs req and pointer; outputs one-hot winner and winner index; purely combinational.
- The counter, limit latch, FSM and pointer register live in cnt_sched.

Test Plan:
- Single requester, req0=1, limit0=4 -> gnt=0001 one cycle later; cnt 0,1,2,3,4; tc only at cnt=4; done=0001 the next cycle; busy low 2 cycles after tc.
- All four req high, limits 1,2,0,3 -> grants in order 0,1,2,3. RUN lengths 2,3,1,4 cycles; one done pulse each, matching gnt; 2-cycle gaps between grants.
- req1 dropped while cnt=2 (limit1=5) -> next cycle gnt=0, cnt=0, abort=1, done stays 0; the next pending requester is granted the cycle after.
- limit2=7 (CW=3) -> cnt counts 0..7, tc at 7, no wrap to 0 in RUN, done asserted.
- rst pulsed low while RUN at cnt=3 -> all outputs 0 immediately (asynchronous). After release with req3 high, gnt=1000 one cycle later, because the pointer was reset to 0 and no other requester is pending.
- limit0 changed from 4 to 1 during a pass -> the pass still runs 5 cycles; the next grant to requester 0 uses 1.
